// File: rtl/branch_predictor.sv
// Fetch-side 2-bit saturating-counter branch history table with training,
// mispredict detection, a sequenced table clear and saturating statistics.
module branch_predictor #(
   parameter int INDEX_BITS = 4,
   parameter int PC_W       = 16,
   parameter int STAT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PC_W-1:0]   fetch_pc,
   input  logic [4:0]        fetch_opcode,
   output logic              pred_taken,
   input  logic              upd_valid,
   input  logic [PC_W-1:0]   upd_pc,
   input  logic              upd_taken,
   input  logic              upd_pred,
   output logic              mispredict,
   input  logic              clear,
   output logic              busy,
   output logic [STAT_W-1:0] br_count,
   output logic [STAT_W-1:0] mp_count
);

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_CLEAR = 1'b1;
   localparam logic [1:0] WNT     = 2'b01;

   logic [0:0]            state_reg;
   logic [INDEX_BITS-1:0] ptr_reg;
   logic [1:0]            bht_reg [ENTRIES];
   logic [STAT_W-1:0]     br_count_reg;
   logic [STAT_W-1:0]     mp_count_reg;

   logic [INDEX_BITS-1:0] fetch_idx;
   logic [INDEX_BITS-1:0] upd_idx;
   logic                  is_idle;
   logic                  upd_accept;
   logic                  unused_bits;

   // Instructions are 2 bytes wide, so PC bit 0 never selects an entry.
   assign fetch_idx   = fetch_pc[INDEX_BITS:1];
   assign upd_idx     = upd_pc[INDEX_BITS:1];
   assign unused_bits = ^{fetch_pc[PC_W-1:INDEX_BITS+1], fetch_pc[0],
                          upd_pc[PC_W-1:INDEX_BITS+1], upd_pc[0], fetch_opcode[1:0]};

   assign is_idle    = (state_reg == S_IDLE);
   assign busy       = ~is_idle;
   assign upd_accept = is_idle & upd_valid & ~clear;

   assign pred_taken = (fetch_opcode[4:2] == 3'b011) & bht_reg[fetch_idx][1] & ~busy;
   assign mispredict = upd_valid & (upd_taken ^ upd_pred);

   assign br_count = br_count_reg;
   assign mp_count = mp_count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         ptr_reg   <= '0;
      end else if (clear) begin
         // A clear seen mid-sequence restarts the sweep from entry 0.
         state_reg <= S_CLEAR;
         ptr_reg   <= '0;
      end else if (state_reg == S_CLEAR) begin
         if (ptr_reg == INDEX_BITS'(ENTRIES - 1)) begin
            state_reg <= S_IDLE;
            ptr_reg   <= '0;
         end else begin
            ptr_reg <= ptr_reg + 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
         logic clear_hit;
         logic upd_hit;

         assign clear_hit = (state_reg == S_CLEAR) && (ptr_reg == INDEX_BITS'(gi));
         assign upd_hit   = upd_accept && (upd_idx == INDEX_BITS'(gi));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               bht_reg[gi] <= WNT;
            end else if (clear_hit) begin
               bht_reg[gi] <= WNT;
            end else if (upd_hit) begin
               if (upd_taken && bht_reg[gi] != 2'b11) begin
                  bht_reg[gi] <= bht_reg[gi] + 2'b01;
               end else if (!upd_taken && bht_reg[gi] != 2'b00) begin
                  bht_reg[gi] <= bht_reg[gi] - 2'b01;
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count_reg <= '0;
         mp_count_reg <= '0;
      end else if (clear) begin
         br_count_reg <= '0;
         mp_count_reg <= '0;
      end else if (upd_accept) begin
         if (br_count_reg != '1) begin
            br_count_reg <= br_count_reg + 1'b1;
         end
         if (mispredict && mp_count_reg != '1) begin
            mp_count_reg <= mp_count_reg + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

   logic        clk;
   logic        rst_n;
   logic [15:0] fetch_pc;
   logic [4:0]  fetch_opcode;
   logic        pred_taken;
   logic        upd_valid;
   logic [15:0] upd_pc;
   logic        upd_taken;
   logic        upd_pred;
   logic        mispredict;
   logic        clear;
   logic        busy;
   logic [15:0] br_count;
   logic [15:0] mp_count;

   int checks_total;
   int errors_total;

   branch_predictor #(.INDEX_BITS(4), .PC_W(16), .STAT_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fetch_pc     (fetch_pc),
      .fetch_opcode (fetch_opcode),
      .pred_taken   (pred_taken),
      .upd_valid    (upd_valid),
      .upd_pc       (upd_pc),
      .upd_taken    (upd_taken),
      .upd_pred     (upd_pred),
      .mispredict   (mispredict),
      .clear        (clear),
      .busy         (busy),
      .br_count     (br_count),
      .mp_count     (mp_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_total++;
      if (got !== exp) begin
         errors_total++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_upd(input logic [15:0] pc, input logic t, input logic p);
      upd_valid = 1'b1;
      upd_pc    = pc;
      upd_taken = t;
      upd_pred  = p;
      step();
      upd_valid = 1'b0;
   endtask

   task automatic fetch(input logic [15:0] pc, input logic [4:0] op);
      fetch_pc     = pc;
      fetch_opcode = op;
      #1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 40) begin
         step();
         n++;
      end
      check(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      checks_total = 0;
      errors_total = 0;
      rst_n = 1'b0; fetch_pc = '0; fetch_opcode = '0; upd_valid = 1'b0;
      upd_pc = '0; upd_taken = 1'b0; upd_pred = 1'b0; clear = 1'b0;

      // 1: reset state and opcode decode
      repeat (2) step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_br", 32'(br_count), 32'd0);
      check("rst_mp", 32'(mp_count), 32'd0);
      rst_n = 1'b1;
      step();
      fetch(16'h0004, 5'b01100);
      check("t1_wnt_pred", 32'(pred_taken), 32'd0);
      fetch(16'h0040, 5'b01100);
      check("t1_wnt_pred_pc40", 32'(pred_taken), 32'd0);

      // 2: train to ST, aliasing
      do_upd(16'h0004, 1'b1, 1'b0);
      do_upd(16'h0004, 1'b1, 1'b1);
      fetch(16'h0004, 5'b01101);
      check("t2_st_pred", 32'(pred_taken), 32'd1);
      fetch(16'h0024, 5'b01101);
      check("t2_alias_pred", 32'(pred_taken), 32'd1);
      fetch(16'h0004, 5'b00000);
      check("t1_nonbranch", 32'(pred_taken), 32'd0);
      fetch(16'h0004, 5'b01000);
      check("t1_nonbranch_010", 32'(pred_taken), 32'd0);

      // 3: saturation both ends
      fetch(16'h0004, 5'b01110);
      repeat (3) do_upd(16'h0004, 1'b1, 1'b1);
      check("t3_sat_hi", 32'(pred_taken), 32'd1);
      do_upd(16'h0004, 1'b0, 1'b1);
      check("t3_nt1_wt", 32'(pred_taken), 32'd1);
      do_upd(16'h0004, 1'b0, 1'b1);
      check("t3_nt2_wnt", 32'(pred_taken), 32'd0);
      do_upd(16'h0004, 1'b0, 1'b0);
      do_upd(16'h0004, 1'b0, 1'b0);
      do_upd(16'h0004, 1'b1, 1'b0);
      check("t3_sat_lo_t1", 32'(pred_taken), 32'd0);
      do_upd(16'h0004, 1'b1, 1'b0);
      check("t3_sat_lo_t2", 32'(pred_taken), 32'd1);

      // 5: clear sequence
      do_upd(16'h0006, 1'b1, 1'b0);
      do_upd(16'h0006, 1'b1, 1'b1);
      fetch(16'h0006, 5'b01111);
      check("t5_e3_trained", 32'(pred_taken), 32'd1);
      check("t5_br_nonzero", 32'(br_count != 0), 32'd1);
      pulse_clear();
      check("t5_busy", 32'(busy), 32'd1);
      check("t5_br_zero", 32'(br_count), 32'd0);
      check("t5_mp_zero", 32'(mp_count), 32'd0);
      check("t5_pred_gated", 32'(pred_taken), 32'd0);
      n = 0;
      while (busy && n < 40) begin
         upd_valid = (n == 5);
         upd_pc = 16'h0000; upd_taken = 1'b1; upd_pred = 1'b0;
         step();
         n++;
      end
      upd_valid = 1'b0;
      check("t5_busy_cycles", 32'(n), 32'd16);
      check("t5_e3_wnt", 32'(pred_taken), 32'd0);
      fetch(16'h0000, 5'b01100);
      check("t5_drop_upd", 32'(pred_taken), 32'd0);
      fetch(16'h0004, 5'b01100);
      check("t5_e2_wnt", 32'(pred_taken), 32'd0);
      check("t5_br_drop", 32'(br_count), 32'd0);

      // 4: mispredict and stats
      upd_valid = 1'b1; upd_pc = 16'h0010; upd_taken = 1'b1; upd_pred = 1'b0;
      #1;
      check("t4_mp_comb", 32'(mispredict), 32'd1);
      step();
      upd_valid = 1'b0;
      #1;
      check("t4_mp_invalid", 32'(mispredict), 32'd0);
      check("t4_br1", 32'(br_count), 32'd1);
      check("t4_mp1", 32'(mp_count), 32'd1);
      upd_valid = 1'b1; upd_taken = 1'b1; upd_pred = 1'b1;
      #1;
      check("t4_no_mp", 32'(mispredict), 32'd0);
      step();
      upd_valid = 1'b0;
      check("t4_br2", 32'(br_count), 32'd2);
      check("t4_mp_hold", 32'(mp_count), 32'd1);

      // clear and update in the same idle cycle: clear wins
      upd_valid = 1'b1; upd_pc = 16'h0008; upd_taken = 1'b1; upd_pred = 1'b0;
      pulse_clear();
      upd_valid = 1'b0;
      check("cu_br_zero", 32'(br_count), 32'd0);
      wait_idle("cu_idle");
      check("cu_br_still0", 32'(br_count), 32'd0);

      // 6: no bypass on same-index read/write
      fetch(16'h000A, 5'b01100);
      upd_valid = 1'b1; upd_pc = 16'h000A; upd_taken = 1'b1; upd_pred = 1'b0;
      #1;
      check("t6_no_bypass", 32'(pred_taken), 32'd0);
      step();
      upd_valid = 1'b0;
      #1;
      check("t6_next_cycle", 32'(pred_taken), 32'd1);

      // 6: statistic saturation
      pulse_clear();
      wait_idle("t6_idle");
      upd_valid = 1'b1; upd_pc = 16'h0002; upd_taken = 1'b0; upd_pred = 1'b0;
      repeat (65534) @(posedge clk);
      #1;
      upd_valid = 1'b0;
      check("t6_br_fffe", 32'(br_count), 32'h0000_FFFE);
      check("t6_mp_zero", 32'(mp_count), 32'd0);
      do_upd(16'h0002, 1'b0, 1'b0);
      do_upd(16'h0002, 1'b0, 1'b0);
      check("t6_br_sat", 32'(br_count), 32'h0000_FFFF);

      // async reset in the middle of a clear sweep
      pulse_clear();
      repeat (3) step();
      check("ar_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("ar_busy_after", 32'(busy), 32'd0);
      check("ar_br_after", 32'(br_count), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("ar_idle_hold", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks_total, errors_total);
      $finish;
   end

endmodule
